// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: registered D->X control decode with scoreboard hazards and jump bubbles.
// Optional macro HAZARD_FWD_EN: forwarding with load-use-only stalls.
module riscv_pipe_ctrl #(
  parameter int WB_STAGES   = 2,
  parameter int JMP_BUBBLES = 1,
  parameter int FW          = $clog2(WB_STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_valid,
  input  logic [31:0]   f_inst,
  output logic          f_ready,
  output logic          stall,
  input  logic          x_redirect,
  output logic          x_valid,
  output logic [31:0]   x_inst,
  output logic          x_regwen,
  output logic          x_memrw,
  output logic          x_asel,
  output logic          x_bsel,
  output logic [1:0]    x_wbsel,
  output logic [3:0]    x_store_mask,
  output logic [FW-1:0] x_fwd_a,
  output logic [FW-1:0] x_fwd_b
);

  localparam int NS = WB_STAGES + 1;

  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;

  assign op  = f_inst[6:0];
  assign rd  = f_inst[11:7];
  assign f3  = f_inst[14:12];
  assign rs1 = f_inst[19:15];
  assign rs2 = f_inst[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_opi, is_op;

  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;

  logic       d_regwen, d_memrw, d_asel, d_bsel;
  logic       use1, use2;
  logic [1:0] d_wbsel;
  logic [3:0] d_mask;

  always_comb begin
    d_regwen = 1'b0;
    d_memrw  = 1'b0;
    d_asel   = 1'b0;
    d_bsel   = 1'b1;
    d_wbsel  = 2'b01;
    d_mask   = 4'b0000;
    use1     = 1'b0;
    use2     = 1'b0;
    unique case (1'b1)
      is_op: begin
        d_regwen = 1'b1;
        d_bsel   = 1'b0;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      is_opi: begin
        d_regwen = 1'b1;
        use1     = 1'b1;
      end
      is_ld: begin
        d_regwen = 1'b1;
        d_wbsel  = 2'b00;
        use1     = 1'b1;
      end
      is_st: begin
        d_memrw = 1'b1;
        use1    = 1'b1;
        use2    = 1'b1;
        case (f3)
          3'b000:  d_mask = 4'b0001;
          3'b001:  d_mask = 4'b0011;
          3'b010:  d_mask = 4'b1111;
          default: d_mask = 4'b0000;
        endcase
      end
      is_br: begin
        d_asel = 1'b1;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      is_jal: begin
        d_regwen = 1'b1;
        d_asel   = 1'b1;
        d_wbsel  = 2'b10;
      end
      is_jalr: begin
        d_regwen = 1'b1;
        d_wbsel  = 2'b10;
        use1     = 1'b1;
      end
      is_lui:   d_regwen = 1'b1;
      is_auipc: begin
        d_regwen = 1'b1;
        d_asel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Index 0 is X, index j is Mj.
  logic [NS-1:0] sb_v, sb_wen, sb_ld;
  logic [4:0]    sb_rd [NS];
  logic [NS-1:0] hit1, hit2;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < NS; i++) begin
      hit1[i] = sb_v[i] & sb_wen[i] & (sb_rd[i] != 5'd0)
              & use1 & (sb_rd[i] == rs1);
      hit2[i] = sb_v[i] & sb_wen[i] & (sb_rd[i] != 5'd0)
              & use2 & (sb_rd[i] == rs2);
    end
  end

  logic hazard;

`ifdef HAZARD_FWD_EN
  logic [FW-1:0] fa, fb;
  logic          unused_ok;

  assign hazard    = sb_ld[0] & (hit1[0] | hit2[0]);
  assign unused_ok = ^sb_ld[NS-1:1];

  // Oldest first so the youngest match wins; the last stage is write-through.
  always_comb begin
    fa = '0;
    fb = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit1[i]) fa = (i >= WB_STAGES) ? '0 : FW'(i + 1);
      if (hit2[i]) fb = (i >= WB_STAGES) ? '0 : FW'(i + 1);
    end
  end
`else
  logic unused_ok;

  assign hazard    = |{hit1[WB_STAGES-1:0], hit2[WB_STAGES-1:0]};
  assign unused_ok = ^{sb_ld, hit1[WB_STAGES], hit2[WB_STAGES]};
  assign x_fwd_a   = '0;
  assign x_fwd_b   = '0;
`endif

  logic [2:0] cnt;
  logic       accept;

  assign f_ready  = ~hazard & (cnt == 3'd0);
  assign stall    = f_valid & ~f_ready;
  assign accept   = f_valid & f_ready & ~x_redirect;
  assign x_valid  = sb_v[0];
  assign x_regwen = sb_wen[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_v         <= '0;
      sb_wen       <= '0;
      sb_ld        <= '0;
      for (int i = 0; i < NS; i++) sb_rd[i] <= '0;
      x_inst       <= '0;
      x_memrw      <= 1'b0;
      x_asel       <= 1'b0;
      x_bsel       <= 1'b0;
      x_wbsel      <= 2'b00;
      x_store_mask <= 4'b0000;
`ifdef HAZARD_FWD_EN
      x_fwd_a      <= '0;
      x_fwd_b      <= '0;
`endif
      cnt          <= 3'd0;
    end else begin
      for (int i = 1; i < NS; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_wen[i] <= sb_wen[i-1];
        sb_ld[i]  <= sb_ld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
      if (accept) begin
        sb_v[0]      <= 1'b1;
        sb_wen[0]    <= d_regwen;
        sb_ld[0]     <= is_ld;
        sb_rd[0]     <= rd;
        x_inst       <= f_inst;
        x_memrw      <= d_memrw;
        x_asel       <= d_asel;
        x_bsel       <= d_bsel;
        x_wbsel      <= d_wbsel;
        x_store_mask <= d_mask;
`ifdef HAZARD_FWD_EN
        x_fwd_a      <= fa;
        x_fwd_b      <= fb;
`endif
      end else begin
        sb_v[0]      <= 1'b0;
        sb_wen[0]    <= 1'b0;
        sb_ld[0]     <= 1'b0;
        sb_rd[0]     <= 5'd0;
        x_inst       <= '0;
        x_memrw      <= 1'b0;
        x_asel       <= 1'b0;
        x_bsel       <= 1'b0;
        x_wbsel      <= 2'b00;
        x_store_mask <= 4'b0000;
`ifdef HAZARD_FWD_EN
        x_fwd_a      <= '0;
        x_fwd_b      <= '0;
`endif
      end
      if (x_redirect)
        cnt <= 3'd0;
      else if (accept && (is_jal || is_jalr))
        cnt <= 3'(JMP_BUBBLES);
      else if (cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb_riscv_pipe_ctrl: directed decode table plus hazard, jump and redirect sequences.
// Expectations follow HAZARD_FWD_EN when the bench is built with it.
module tb_riscv_pipe_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int WB = 2;
  localparam int FWW = $clog2(WB + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            f_valid;
  logic [31:0]     f_inst;
  logic            f_ready;
  logic            stall;
  logic            x_redirect;
  logic            x_valid;
  logic [31:0]     x_inst;
  logic            x_regwen;
  logic            x_memrw;
  logic            x_asel;
  logic            x_bsel;
  logic [1:0]      x_wbsel;
  logic [3:0]      x_store_mask;
  logic [FWW-1:0]  x_fwd_a;
  logic [FWW-1:0]  x_fwd_b;

  riscv_pipe_ctrl #(
    .WB_STAGES(WB),
    .JMP_BUBBLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f_valid(f_valid),
    .f_inst(f_inst),
    .f_ready(f_ready),
    .stall(stall),
    .x_redirect(x_redirect),
    .x_valid(x_valid),
    .x_inst(x_inst),
    .x_regwen(x_regwen),
    .x_memrw(x_memrw),
    .x_asel(x_asel),
    .x_bsel(x_bsel),
    .x_wbsel(x_wbsel),
    .x_store_mask(x_store_mask),
    .x_fwd_a(x_fwd_a),
    .x_fwd_b(x_fwd_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int bub_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    f_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold inst in D until accepted; returns the number of stalled cycles.
  task automatic issue(input logic [31:0] inst, output int stalls);
    logic rdy, stl, done;
    stalls = 0;
    done = 1'b0;
    f_valid = 1'b1;
    f_inst = inst;
    for (int n = 0; n < 16 && !done; n++) begin
      @(negedge clk);
      rdy = f_ready;
      stl = stall;
      if (stl !== ~rdy) bub_bad++;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else begin
        stalls++;
        if (x_valid !== 1'b0) bub_bad++;
      end
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL issue_timeout: inst %0h never accepted", inst);
    end
    f_valid = 1'b0;
  endtask

  function automatic logic [10:0] mk(input logic r, input logic m,
                                     input logic a, input logic b,
                                     input logic [1:0] w,
                                     input logic [3:0] k);
    return {1'b1, r, m, a, b, w, k};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [10:0] ctrl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s;

    vecs[0]  = '{"lui",   32'h000001B7, mk(1, 0, 0, 1, 2'b01, 4'b0000)};
    vecs[1]  = '{"auipc", 32'h00000197, mk(1, 0, 1, 1, 2'b01, 4'b0000)};
    vecs[2]  = '{"jal",   32'h000001EF, mk(1, 0, 1, 1, 2'b10, 4'b0000)};
    vecs[3]  = '{"jalr",  32'h000001E7, mk(1, 0, 0, 1, 2'b10, 4'b0000)};
    vecs[4]  = '{"beq",   32'h00000063, mk(0, 0, 1, 1, 2'b01, 4'b0000)};
    vecs[5]  = '{"lw",    32'h00002183, mk(1, 0, 0, 1, 2'b00, 4'b0000)};
    vecs[6]  = '{"sw",    32'h00002023, mk(0, 1, 0, 1, 2'b01, 4'b1111)};
    vecs[7]  = '{"sh",    32'h00001023, mk(0, 1, 0, 1, 2'b01, 4'b0011)};
    vecs[8]  = '{"sb",    32'h00000023, mk(0, 1, 0, 1, 2'b01, 4'b0001)};
    vecs[9]  = '{"addi",  32'h00000193, mk(1, 0, 0, 1, 2'b01, 4'b0000)};
    vecs[10] = '{"add",   32'h000001B3, mk(1, 0, 0, 0, 2'b01, 4'b0000)};
    vecs[11] = '{"unk",   32'h0000007F, mk(0, 0, 0, 1, 2'b01, 4'b0000)};

    rst_n = 1'b0;
    f_valid = 1'b1;
    f_inst = 32'h00100293;
    x_redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_valid", {31'd0, x_valid}, 0);
    chk("rst_regwen", {31'd0, x_regwen}, 0);
    chk("rst_mask", {28'd0, x_store_mask}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    rst_n = 1'b1;
    issue(32'h00100293, s);
    chk("rst_first_stalls", 32'(s), 0);
    chk("rst_first_valid", {31'd0, x_valid}, 1);
    chk("rst_first_inst", x_inst, 32'h00100293);
    idle(4);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].inst, s);
      chk({vecs[i].name, "_stalls"}, 32'(s), 0);
      chk({vecs[i].name, "_inst"}, x_inst, vecs[i].inst);
      chk({vecs[i].name, "_ctrl"},
          {21'd0, x_valid, x_regwen, x_memrw, x_asel, x_bsel,
           x_wbsel, x_store_mask},
          {21'd0, vecs[i].ctrl});
      idle(3);
    end

    // ADDI x5 -> ADD x6,x5,x5 back to back
    issue(32'h00100293, s);
    issue(32'h00528333, s);
    chk("b2b_stalls", 32'(s), FWD ? 0 : 2);
    chk("b2b_inst", x_inst, 32'h00528333);
    chk("b2b_fwd_a", 32'(x_fwd_a), FWD ? 1 : 0);
    chk("b2b_fwd_b", 32'(x_fwd_b), FWD ? 1 : 0);
    idle(4);

    // one instruction between producer and consumer
    issue(32'h00100293, s);
    issue(32'h00000493, s);
    issue(32'h00528333, s);
    chk("gap1_stalls", 32'(s), FWD ? 0 : 1);
    chk("gap1_fwd_a", 32'(x_fwd_a), FWD ? 2 : 0);
    idle(4);

    // producer in the last stage: write-through
    issue(32'h00100293, s);
    issue(32'h00000013, s);
    issue(32'h00000013, s);
    issue(32'h00528333, s);
    chk("gap2_stalls", 32'(s), 0);
    chk("gap2_fwd_a", 32'(x_fwd_a), 0);
    idle(4);

    // LW x7,0(x1) -> ADD x8,x7,x2
    issue(32'h0000A383, s);
    issue(32'h00238433, s);
    chk("ldu_stalls", 32'(s), FWD ? 1 : 2);
    chk("ldu_inst", x_inst, 32'h00238433);
    chk("ldu_fwd_a", 32'(x_fwd_a), FWD ? 2 : 0);
    chk("ldu_fwd_b", 32'(x_fwd_b), 0);
    idle(4);

    // JAL x1,8 then a follower held for the jump bubbles
    issue(32'h008000EF, s);
    chk("jal_stalls", 32'(s), 0);
    chk("jal_wbsel", {30'd0, x_wbsel}, 2);
    chk("jal_asel", {31'd0, x_asel}, 1);
    issue(32'h00000513, s);
    chk("jal_bubbles", 32'(s), 2);
    chk("jal_follow_inst", x_inst, 32'h00000513);
    idle(4);

    // redirect during the first jump bubble clears the counter
    issue(32'h008000EF, s);
    f_valid = 1'b1;
    f_inst = 32'h00000513;
    x_redirect = 1'b1;
    @(negedge clk);
    chk("rdj_ready_cnt", {31'd0, f_ready}, 0);
    @(posedge clk);
    #1;
    x_redirect = 1'b0;
    chk("rdj_x_bubble", {31'd0, x_valid}, 0);
    @(negedge clk);
    chk("rdj_ready_after", {31'd0, f_ready}, 1);
    @(posedge clk);
    #1;
    chk("rdj_accept", {31'd0, x_valid}, 1);
    // redirect kills an otherwise ready instruction
    x_redirect = 1'b1;
    f_inst = 32'h00000593;
    @(negedge clk);
    chk("rdk_ready", {31'd0, f_ready}, 1);
    @(posedge clk);
    #1;
    x_redirect = 1'b0;
    chk("rdk_killed", {31'd0, x_valid}, 0);
    idle(4);

    // redirect during a load-use stall
    issue(32'h0000A383, s);
    f_valid = 1'b1;
    f_inst = 32'h00238433;
    x_redirect = 1'b1;
    @(negedge clk);
    chk("rdl_ready", {31'd0, f_ready}, 0);
    @(posedge clk);
    #1;
    x_redirect = 1'b0;
    chk("rdl_x_bubble", {31'd0, x_valid}, 0);
    issue(32'h00238433, s);
    chk("rdl_stalls", 32'(s), FWD ? 0 : 1);
    chk("rdl_fwd_a", 32'(x_fwd_a), FWD ? 2 : 0);
    idle(4);

    // write x0 then read x0
    issue(32'h00500013, s);
    issue(32'h000005B3, s);
    chk("x0_stalls", 32'(s), 0);
    chk("x0_fwd_a", 32'(x_fwd_a), 0);
    chk("x0_fwd_b", 32'(x_fwd_b), 0);
    idle(2);

    chk("stall_bubble_consistency", 32'(bub_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
